// File: rtl/gh_ocram_arbiter.sv
// gh_ocram_arbiter: round-robin arbiter letting two Avalon-MM masters share one single-port RAM.
// Define GH_OCRAM_ARB_STATS_EN to add the m0_grant_cnt / m1_grant_cnt counters.
module gh_ocram_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                mem_clken,
    output logic                mem_reset_req
`ifdef GH_OCRAM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]    m0_grant_cnt,
    output logic [CNT_W-1:0]    m1_grant_cnt
`endif
);

    localparam int BE_W = DATA_W / 8;

    if (CNT_W < 1 || BE_W * 8 != DATA_W) begin : g_param_check
        $error("gh_ocram_arbiter: bad CNT_W or DATA_W");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RDATA = 2'd2} state_t;

    state_t              state_reg, state_next;
    logic                last_grant_reg, last_grant_next;
    logic [ADDR_W-1:0]   mem_address_reg, mem_address_next;
    logic                mem_chipselect_reg, mem_chipselect_next;
    logic                mem_write_reg, mem_write_next;
    logic [BE_W-1:0]     mem_byteenable_reg, mem_byteenable_next;
    logic [DATA_W-1:0]   mem_writedata_reg, mem_writedata_next;

    logic [1:0]          req;
    logic [1:0]          wr;
    logic [ADDR_W-1:0]   req_addr [2];
    logic [BE_W-1:0]     req_be   [2];
    logic [DATA_W-1:0]   req_data [2];
    logic                winner;
    logic [1:0]          waitrequest;
    logic [1:0]          readdatavalid;
    logic [DATA_W-1:0]   readdata [2];

    assign req[0]      = m0_read | m0_write;
    assign req[1]      = m1_read | m1_write;
    assign wr[0]       = m0_write;
    assign wr[1]       = m1_write;
    assign req_addr[0] = m0_address;
    assign req_addr[1] = m1_address;
    assign req_be[0]   = m0_byteenable;
    assign req_be[1]   = m1_byteenable;
    assign req_data[0] = m0_writedata;
    assign req_data[1] = m1_writedata;

    // On a tie the master that did not win last time gets the RAM.
    assign winner = (&req) ? ~last_grant_reg : req[1];

    always_comb begin
        state_next          = state_reg;
        last_grant_next     = last_grant_reg;
        mem_address_next    = mem_address_reg;
        mem_chipselect_next = mem_chipselect_reg;
        mem_write_next      = mem_write_reg;
        mem_byteenable_next = mem_byteenable_reg;
        mem_writedata_next  = mem_writedata_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    mem_address_next    = req_addr[winner];
                    mem_byteenable_next = req_be[winner];
                    mem_writedata_next  = req_data[winner];
                    mem_write_next      = wr[winner];
                    mem_chipselect_next = 1'b1;
                    last_grant_next     = winner;
                    state_next          = ISSUE;
                end
            end
            ISSUE: begin
                mem_chipselect_next = 1'b0;
                mem_write_next      = 1'b0;
                state_next          = mem_write_reg ? IDLE : RDATA;
            end
            RDATA: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            last_grant_reg     <= 1'b1;
            mem_address_reg    <= '0;
            mem_chipselect_reg <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_byteenable_reg <= '0;
            mem_writedata_reg  <= '0;
        end else begin
            state_reg          <= state_next;
            last_grant_reg     <= last_grant_next;
            mem_address_reg    <= mem_address_next;
            mem_chipselect_reg <= mem_chipselect_next;
            mem_write_reg      <= mem_write_next;
            mem_byteenable_reg <= mem_byteenable_next;
            mem_writedata_reg  <= mem_writedata_next;
        end
    end

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_master
        localparam logic ID = 1'(gi);

        logic [DATA_W-1:0] readdata_reg;
        logic              readdatavalid_reg;
        logic              capture;

        // RAM q is valid during RDATA; the pulse lands one cycle later with the data.
        assign capture = (state_reg == RDATA) && (last_grant_reg == ID);

        always_ff @(posedge clk) begin
            if (reset) begin
                readdata_reg      <= '0;
                readdatavalid_reg <= 1'b0;
            end else begin
                readdatavalid_reg <= capture;
                if (capture) begin
                    readdata_reg <= mem_readdata;
                end
            end
        end

        assign waitrequest[gi]   = !((state_reg == ISSUE) && (last_grant_reg == ID));
        assign readdata[gi]      = readdata_reg;
        assign readdatavalid[gi] = readdatavalid_reg;

`ifdef GH_OCRAM_ARB_STATS_EN
        logic [CNT_W-1:0] grant_cnt_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                grant_cnt_reg <= '0;
            end else if ((state_reg == ISSUE) && (last_grant_reg == ID)) begin
                grant_cnt_reg <= grant_cnt_reg + 1'b1;
            end
        end
`endif
    end

    assign m0_waitrequest   = waitrequest[0];
    assign m1_waitrequest   = waitrequest[1];
    assign m0_readdata      = readdata[0];
    assign m1_readdata      = readdata[1];
    assign m0_readdatavalid = readdatavalid[0];
    assign m1_readdatavalid = readdatavalid[1];

`ifdef GH_OCRAM_ARB_STATS_EN
    assign m0_grant_cnt = g_master[0].grant_cnt_reg;
    assign m1_grant_cnt = g_master[1].grant_cnt_reg;
`endif

    assign mem_address    = mem_address_reg;
    assign mem_chipselect = mem_chipselect_reg;
    assign mem_write      = mem_write_reg;
    assign mem_byteenable = mem_byteenable_reg;
    assign mem_writedata  = mem_writedata_reg;
    assign mem_clken      = 1'b1;
    assign mem_reset_req  = 1'b0;

endmodule

// File: doc/gh_ocram_arbiter.md
Name: gh_ocram_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares the 4-word x 32-bit single-port on-chip RAM.
- Typical masters: m0 = Nios II data master, m1 = hardware note/score engine.
- Sequences each access to the RAM, which has a registered address and an unregistered q, so read data appears 1 cycle after the address is sampled.
- Round-robin fairness; one transaction in flight at a time.

Parameters:
- ADDR_W, 2, word-address width (RAM depth = 2**ADDR_W).
- DATA_W, 32, data width; byteenable width = DATA_W/8.
- CNT_W, 16, width of the optional grant counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mX_address  in  ADDR_W  requester X word address (X = 0, 1; same set of ports for each).
- mX_read / mX_write  in  1 each  request strobes; held until waitrequest is low.
- mX_byteenable  in  DATA_W/8  write byte lanes.
- mX_writedata  in  DATA_W  write data.
- mX_waitrequest  out  1  low for exactly the cycle the command is accepted.
- mX_readdata  out  DATA_W  registered read data.
- mX_readdatavalid  out  1  one-cycle pulse qualifying mX_readdata.
- mem_address  out  ADDR_W  to RAM.
- mem_chipselect / mem_write  out  1 each  to RAM.
- mem_byteenable  out  DATA_W/8  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_readdata  in  DATA_W  from RAM q.
- mem_clken  out  1  tied 1.
- mem_reset_req  out  1  tied 0.
- m0_grant_cnt, m1_grant_cnt  out  CNT_W each  present only with the optional feature.

Behaviour:
- Reset values (state also returns to these on reset):
  - state = IDLE, last_grant = 1 (so m0 wins the first tie).
  - All mem_* registers = 0.
  - mX_readdata = 0, mX_readdatavalid = 0, mX_waitrequest = 1.
- Request: reqX = mX_read | mX_write. If both read and write are asserted, the access is treated as a write.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one requester: grant it.
  - Both requesting: grant the one that is NOT last_grant.
  - On grant: register the winner's address, byteenable, writedata and write into mem_*; mem_chipselect <= 1; last_grant <= winner; go ISSUE.
- ISSUE:
  - mem_* are stable and the RAM samples them at the end of this cycle.
  - Winner's waitrequest = 0 for this cycle only; the loser's waitrequest stays 1.
  - Write: clear mem_chipselect / mem_write, go IDLE.
  - Read: clear mem_chipselect, go RDATA.
- RDATA:
  - mem_readdata is valid; capture it into the winner's mX_readdata.
  - Next cycle: winner's mX_readdatavalid = 1 for exactly one cycle; state is IDLE.
  - Arbitration may occur in that same cycle.
- Latency and throughput:
  - Write: request seen at N, accepted at N+1, RAM written at the N+1 edge, next grant possible at N+2.
  - Read: accepted at N+1, readdatavalid at N+3.
  - Back-to-back reads: a new grant every 3 cycles; writes every 2 cycles.
- Two requesters continuously requesting alternate strictly m0, m1, m0, ...
- A requester dropping its strobe after the grant (Avalon protocol violation): the registered transaction still completes; a read still returns readdatavalid.
- Reset in ISSUE or RDATA: transaction aborted, no readdatavalid pulse; a RAM write already clocked in is not undone.
- Non-granted requester: mX_readdata holds its last value.

Optional Feature:
- Macro: GH_OCRAM_ARB_STATS_EN.
- Defined:
  - mX_grant_cnt increments by 1 on each ISSUE cycle granted to X; wraps at 2**CNT_W.
  - Cleared by reset.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Read, m0 alone: preload word 2 = 0xDEADBEEF; m0_read at addr 2 -> waitrequest low 1 cycle later, m0_readdatavalid 2 cycles after that with 0xDEADBEEF; m1 sees no valid pulse.
- Simultaneous reads after reset: m0 and m1 both read -> m0 granted first; m1 accepted 3 cycles after m0; both receive correct data.
- Fairness: both requesters hold reads continuously for 6 grants -> grant order m0, m1, m0, m1, m0, m1; each waitrequest low exactly 3 times.
- Byte write then read: RAM word 1 = 0x11223344; m1 writes 0xAABBCCDD with byteenable 4'b0101 to addr 1, then m0 reads addr 1 -> 0x11BB33DD.
- Reset mid-read: assert reset during RDATA -> no readdatavalid; all outputs at reset values next cycle; the next tie goes to m0.
- Stats, with GH_OCRAM_ARB_STATS_EN: 5 m0 accesses and 3 m1 accesses -> m0_grant_cnt = 5, m1_grant_cnt = 3; reset clears both to 0.
